// File: rtl/bexkat1_pkg.sv
// Shared types for the bexkat1 pipeline: op codes, access sizes,
// exception causes and the memory/writeback stage state.
package bexkat1_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_ALU   = 3'd1,
        OP_LOAD  = 3'd2,
        OP_STORE = 3'd3,
        OP_PUSH  = 3'd4,
        OP_POP   = 3'd5
    } op_e;

    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_BUSERR   = 2'd2;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_e;

    function automatic logic op_is_mem(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_PUSH) || (op == OP_POP);
    endfunction

    function automatic logic op_is_stack(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering for the data bus: store lanes/data,
// load right-justification and the misalignment flag.
module mem_lane_align
    import bexkat1_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       st_size_i,
    input  logic [1:0]       st_off_i,
    input  logic [WIDTH-1:0] st_data_i,
    output logic [3:0]       sel_o,
    output logic [WIDTH-1:0] dat_o,
    output logic             misalign_o,
    input  logic [1:0]       ld_size_i,
    input  logic [1:0]       ld_off_i,
    input  logic [WIDTH-1:0] ld_data_i,
    output logic [WIDTH-1:0] ld_val_o
);

    logic [WIDTH-1:0] ld_b;
    logic [WIDTH-1:0] ld_h;

    always_comb begin
        sel_o      = 4'b1111;
        dat_o      = st_data_i;
        misalign_o = 1'b0;
        case (st_size_i)
            SZ_BYTE: begin
                sel_o = 4'b1000 >> st_off_i;
                dat_o = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                sel_o      = st_off_i[1] ? 4'b0011 : 4'b1100;
                dat_o      = {2{st_data_i[15:0]}};
                misalign_o = st_off_i[0];
            end
            default: misalign_o = |st_off_i;
        endcase
    end

    // Lane 0 (offset 0) is the most significant byte.
    assign ld_b = ld_data_i >> {~ld_off_i, 3'b000};
    assign ld_h = ld_data_i >> {~ld_off_i[1], 4'b0000};

    always_comb begin
        ld_val_o = ld_data_i;
        case (ld_size_i)
            SZ_BYTE: ld_val_o = {{(WIDTH-8){1'b0}}, ld_b[7:0]};
            SZ_HALF: ld_val_o = {{(WIDTH-16){1'b0}}, ld_h[15:0]};
            default: ld_val_o = ld_data_i;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Memory/writeback stage: runs the data-bus cycle, pulses regfile/SP writes.
// Define MEM_WRITEBACK_TIMEOUT_EN to abort bus cycles after TIMEOUT cycles.
module mem_writeback
    import bexkat1_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNTP  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [2:0]        exe_op,
    input  logic [COUNTP-1:0] exe_reg,
    input  logic [WIDTH-1:0]  exe_result,
    input  logic [WIDTH-1:0]  exe_store,
    input  logic [1:0]        exe_size,
    input  logic [WIDTH-1:0]  exe_sp,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [WIDTH-1:0]  bus_adr_o,
    output logic [3:0]        bus_sel_o,
    output logic [WIDTH-1:0]  bus_dat_o,
    input  logic [WIDTH-1:0]  bus_dat_i,
    input  logic              bus_ack_i,
    input  logic              bus_err_i,
    output logic [COUNTP-1:0] write_addr,
    output logic [WIDTH-1:0]  write_data,
    output logic [1:0]        write_en,
    output logic [WIDTH-1:0]  sp_data,
    output logic [1:0]        sp_en,
    output logic              exc_o,
    output logic [1:0]        exc_cause
);

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  adr_q, adr_d;
    logic [3:0]        sel_q, sel_d;
    logic [WIDTH-1:0]  dat_q, dat_d;
    op_e               op_q, op_d;
    logic [COUNTP-1:0] reg_q, reg_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic [WIDTH-1:0]  sp_q, sp_d;
    logic [COUNTP-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [1:0]        wr_en_q, wr_en_d;
    logic [WIDTH-1:0]  sp_data_q, sp_data_d;
    logic [1:0]        sp_en_q, sp_en_d;
    logic              exc_q, exc_d;
    logic [1:0]        cause_q, cause_d;

    logic              accept;
    logic [1:0]        st_size;
    logic [3:0]        st_sel;
    logic [WIDTH-1:0]  st_dat;
    logic              misalign;
    logic [WIDTH-1:0]  ld_val;
    logic              tmo;

    assign exe_ready = rst_ni && (state_q == S_IDLE);
    assign accept    = exe_valid && exe_ready;
    assign st_size   = op_is_stack(exe_op) ? SZ_WORD : exe_size;

    mem_lane_align #(
        .WIDTH(WIDTH)
    ) u_align (
        .st_size_i (st_size),
        .st_off_i  (exe_result[1:0]),
        .st_data_i (exe_store),
        .sel_o     (st_sel),
        .dat_o     (st_dat),
        .misalign_o(misalign),
        .ld_size_i (size_q),
        .ld_off_i  (off_q),
        .ld_data_i (bus_dat_i),
        .ld_val_o  (ld_val)
    );

`ifdef MEM_WRITEBACK_TIMEOUT_EN
    localparam int CLOG = $clog2(TIMEOUT + 1);
    localparam int CW   = (CLOG > 8) ? CLOG : 8;

    logic [CW-1:0] cnt_q, cnt_d;

    // Counts BUS cycles that end without ack or error.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE)
            cnt_d = '0;
        else if (!bus_ack_i && !bus_err_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tmo = (cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT[0];
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        op_d      = op_q;
        reg_d     = reg_q;
        size_d    = size_q;
        off_d     = off_q;
        sp_d      = sp_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 2'd0;
        sp_data_d = sp_data_q;
        sp_en_d   = 2'd0;
        exc_d     = 1'b0;
        cause_d   = EXC_NONE;
        unique case (state_q)
            S_IDLE: begin
                if (accept && exe_op == OP_ALU) begin
                    wr_addr_d = exe_reg;
                    wr_data_d = exe_result;
                    wr_en_d   = SZ_WORD;
                end else if (accept && op_is_mem(exe_op)) begin
                    if (misalign) begin
                        exc_d   = 1'b1;
                        cause_d = EXC_MISALIGN;
                    end else begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        we_d    = (exe_op == OP_STORE) ||
                                  (exe_op == OP_PUSH);
                        adr_d   = {exe_result[WIDTH-1:2], 2'b00};
                        sel_d   = st_sel;
                        dat_d   = st_dat;
                        op_d    = op_e'(exe_op);
                        reg_d   = exe_reg;
                        size_d  = st_size;
                        off_d   = exe_result[1:0];
                        sp_d    = exe_sp;
                    end
                end
            end
            S_BUS: begin
                if (bus_err_i) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    exc_d   = 1'b1;
                    cause_d = EXC_BUSERR;
                end else if (bus_ack_i) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    unique case (1'b1)
                        op_q == OP_LOAD: begin
                            wr_addr_d = reg_q;
                            wr_data_d = ld_val;
                            wr_en_d   = size_q;
                        end
                        op_q == OP_POP: begin
                            wr_addr_d = reg_q;
                            wr_data_d = ld_val;
                            wr_en_d   = SZ_WORD;
                            sp_data_d = sp_q;
                            sp_en_d   = SZ_WORD;
                        end
                        op_q == OP_PUSH: begin
                            sp_data_d = sp_q;
                            sp_en_d   = SZ_WORD;
                        end
                        default: ;
                    endcase
                end else if (tmo) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    exc_d   = 1'b1;
                    cause_d = EXC_TIMEOUT;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            op_q      <= OP_NONE;
            reg_q     <= '0;
            size_q    <= '0;
            off_q     <= '0;
            sp_q      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= '0;
            sp_data_q <= '0;
            sp_en_q   <= '0;
            exc_q     <= 1'b0;
            cause_q   <= EXC_NONE;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            op_q      <= op_d;
            reg_q     <= reg_d;
            size_q    <= size_d;
            off_q     <= off_d;
            sp_q      <= sp_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            sp_data_q <= sp_data_d;
            sp_en_q   <= sp_en_d;
            exc_q     <= exc_d;
            cause_q   <= cause_d;
        end
    end

    assign bus_cyc_o  = cyc_q;
    assign bus_stb_o  = cyc_q;
    assign bus_we_o   = we_q;
    assign bus_adr_o  = adr_q;
    assign bus_sel_o  = sel_q;
    assign bus_dat_o  = dat_q;
    assign write_addr = wr_addr_q;
    assign write_data = wr_data_q;
    assign write_en   = wr_en_q;
    assign sp_data    = sp_data_q;
    assign sp_en      = sp_en_q;
    assign exc_o      = exc_q;
    assign exc_cause  = cause_q;

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Memory/writeback stage of the bexkat1 pipeline, directly upstream of the register file.
- Accepts one retired operation from execute: ALU result, load, store, push or pop.
- Runs the data-bus cycle when the operation needs one.
- Drives the register file write ports (write_addr/write_data/write_en) and SP ports (sp_data/sp_en) as registered one-cycle pulses.

Parameters:
- WIDTH, 32, data/address width.
- COUNTP, 4, register address bits.
- TIMEOUT, 255, bus watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- exe_valid  in  1  operation offered.
- exe_ready  out  1  stage can accept.
- exe_op  in  3  NONE/ALU/LOAD/STORE/PUSH/POP.
- exe_reg  in  COUNTP  destination register (ALU/LOAD/POP).
- exe_result  in  WIDTH  ALU result, or effective address for memory ops.
- exe_store  in  WIDTH  store/push data.
- exe_size  in  2  1=byte, 2=half, 3=word.
- exe_sp  in  WIDTH  adjusted stack pointer (PUSH/POP).
- bus_cyc_o  out  1  bus cycle active.
- bus_stb_o  out  1  strobe.
- bus_we_o  out  1  write.
- bus_adr_o  out  WIDTH  word-aligned address.
- bus_sel_o  out  4  byte lanes.
- bus_dat_o  out  WIDTH  write data.
- bus_dat_i  in  WIDTH  read data.
- bus_ack_i  in  1  ack.
- bus_err_i  in  1  error.
- write_addr  out  COUNTP  register file write address.
- write_data  out  WIDTH  register file write data.
- write_en  out  2  register file write size (0 = none).
- sp_data  out  WIDTH  new SP value.
- sp_en  out  2  SP write size (3 = word, 0 = none).
- exc_o  out  1  one-cycle exception pulse.
- exc_cause  out  2  0=none, 1=misalign, 2=bus error, 3=timeout.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; exe_ready 0 while rst_ni is low.
  - Reset mid-bus drops cyc/stb asynchronously.
  - The pending operation is discarded with no register/SP write.
- States:
  - IDLE: exe_ready=1.
  - BUS: exe_ready=0, cyc=stb=1.
- Handshake: accept when exe_valid&&exe_ready. Once in BUS, no further accept until the bus cycle ends.
- NONE: accepted, no effect.
- ALU accepted at cycle N:
  - At N+1: write_addr=exe_reg, write_data=exe_result, write_en=3 for one cycle.
  - State stays IDLE, so back-to-back ALU ops retire one per cycle.
- Memory ops accepted at N:
  - If misaligned (half with adr[0]=1, word with adr[1:0]!=0): no bus cycle; at N+1 exc_o=1, exc_cause=1, no writes.
  - Otherwise enter BUS with outputs registered at N+1:
    - bus_adr_o = {adr[31:2],2'b00}; bus_we_o=1 for STORE/PUSH.
    - Big-endian lanes:
      - byte: sel=4'b1000>>adr[1:0], data replicated in all lanes.
      - half: sel=adr[1]?0011:1100.
      - word: sel=1111.
- Ack sampled at cycle M:
  - cyc/stb deassert at M+1; return to IDLE at M+1, so a new op can be accepted at M+1.
  - Register outputs pulse at M+1:
    - LOAD/POP: selected lane right-justified in write_data, write_en=exe_size; the register file zero-extends.
    - POP: write_en always 3; sp_data=exe_sp, sp_en=3 in the same cycle as the register write.
    - PUSH: sp_en=3 only; no register write.
    - STORE: no writes.
- bus_err_i at M (has priority over a simultaneous ack):
  - End the cycle; no register or SP write.
  - exc_o=1, exc_cause=2 at M+1.
- All operation fields are latched at accept; execute may change its inputs during BUS.
- write_en/sp_en are never held longer than one cycle.

Optional Feature:
- MEM_WRITEBACK_TIMEOUT_EN defined:
  - An 8-bit+ counter clears on entry to BUS and increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT, the cycle is aborted: cyc/stb low next cycle, exc_o=1, exc_cause=3, no writes, back to IDLE.
- Not defined:
  - No counter; BUS waits indefinitely.
  - exc_cause=3 is never produced.

Decomposition:
- bexkat1_pkg holds:
  - the op enum (OP_NONE..OP_POP);
  - size constants SZ_BYTE=1, SZ_HALF=2, SZ_WORD=3;
  - exception cause constants;
  - the state enum {S_IDLE,S_BUS}.
- One natural sub-module: mem_lane_align (combinational).
  - Store side: size+adr[1:0] -> bus_sel_o/bus_dat_o.
  - Load side: bus_dat_i -> right-justified load value.
  - Also produces the misalign flag.

Test Plan:
- ALU op exe_reg=5, result=0xDEADBEEF at N -> write_addr=5, write_data=0xDEADBEEF, write_en=3 at N+1 only; two consecutive ALU ops retire on consecutive cycles.
- LOAD byte adr=0x1002, bus_dat_i=0x11223344, ack after 3 wait cycles -> bus_adr_o=0x1000, sel=0010, write_data[7:0]=0x33, write_en=1, one cycle after ack.
- POP reg 3, adr=0x2000, exe_sp=0x2004, data 0xCAFEF00D -> write_addr=3, write_data=0xCAFEF00D, write_en=3, and sp_data=0x2004, sp_en=3, all in the same cycle.
- STORE half adr=0x3001 -> no cyc/stb; exc_o=1 with exc_cause=1 for one cycle; then STORE half adr=0x3002 data 0xABCD -> sel=0011, we=1, no register writes.
- PUSH with bus_err_i and bus_ack_i both high -> exc_cause=2, sp_en stays 0; reset asserted during a BUS wait -> cyc/stb drop immediately and no write follows reset release.
- With MEM_WRITEBACK_TIMEOUT_EN, TIMEOUT=4, no ack -> abort after 4 BUS cycles, exc_cause=3, exe_ready=1 the next cycle.
